text_cursor_ctrl: RTL

Upstream feeder for the character-typer stage.
- Accepts a stream of ASCII key codes from the keyboard decoder and buffers them in a small FIFO.
- Maintains the text cursor (row, column) for the on-screen text area.
- Issues one character-write request at a time to the typer using its start/finished handshake.
- Handles printable characters, newline and backspace, including line and screen wrap-around.

---
 rtl/text_cursor_ctrl_pkg.sv | 58 +++++
 rtl/text_cursor_ctrl_key_fifo.sv | 89 ++++++++
 rtl/text_cursor_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_cursor_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// text_cursor_ctrl_pkg
// Shared definitions for the text cursor controller and the character typer:
//   - ASCII codes the controller recognises
//   - FSM state encoding of the controller
//   - text-area geometry constants (pixel sizes of a glyph cell, text origin)
//   - cursor position type and key-code classification helper
// -----------------------------------------------------------------------------
package text_cursor_ctrl_pkg;

    // ASCII codes
    localparam logic [7:0] ASCII_BS        = 8'h08;
    localparam logic [7:0] ASCII_LF        = 8'h0A;
    localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
    localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

    // Text-area geometry in pixels, shared with the typer
    localparam int CHAR_WIDTH  = 20;
    localparam int CHAR_HEIGHT = 30;
    localparam int TEXT_Y0     = 270;

    // Controller FSM state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;

    // Class of a buffered key code
    typedef enum logic [1:0] {
        CLS_PRINT     = 2'd0,
        CLS_NEWLINE   = 2'd1,
        CLS_BACKSPACE = 2'd2,
        CLS_OTHER     = 2'd3
    } code_class_e;

    // Cursor position in character cells
    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
    } cursor_t;

    // Sort a key code into the class that decides what the controller does
    function automatic code_class_e classify_code(input logic [7:0] code);
        code_class_e cls;
        if ((code >= ASCII_PRINT_MIN) && (code <= ASCII_PRINT_MAX)) begin
            cls = CLS_PRINT;
        end else if (code == ASCII_LF) begin
            cls = CLS_NEWLINE;
        end else if (code == ASCII_BS) begin
            cls = CLS_BACKSPACE;
        end else begin
            cls = CLS_OTHER;
        end
        return cls;
    endfunction

endpackage

// File: rtl/text_cursor_ctrl_key_fifo.sv
// -----------------------------------------------------------------------------
// key_fifo
// Synchronous FIFO buffering key codes between the keyboard decoder and the
// cursor controller. DEPTH must be a power of two so the pointers wrap freely.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   push/push_data : write request and data (ignored while full)
//   pop            : read request (ignored while empty)
//   pop_data       : current head entry
//   full, empty    : registered occupancy flags
// -----------------------------------------------------------------------------
module key_fifo
    import text_cursor_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Flags are registered, so a push in the same cycle as a pop while full
    // is still rejected.
    assign push_ok_s = push & ~full_r;
    assign pop_ok_s  = pop & ~empty_r;

    // Next occupancy from the accepted push/pop pair
    always_comb begin
        count_nxt_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_nxt_s = count_r + (AW+1)'(1);
        end else if (!push_ok_s && pop_ok_s) begin
            count_nxt_s = count_r - (AW+1)'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, occupancy and flags
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == (AW+1)'(DEPTH));
            empty_r <= (count_nxt_s == (AW+1)'(0));
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;

endmodule

// File: rtl/text_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// text_cursor_ctrl
// Feeds the character typer. Buffers incoming key codes, keeps the text
// cursor, and issues one write request at a time over the typer's
// start / finished handshake. Handles printable characters, newline and
// backspace, including line and screen wrap-around.
// Ports:
//   clock, reset             : clock and synchronous active-high reset
//   key_valid, key_ascii     : key stream from the keyboard decoder
//   key_ready                : buffer can take a key this cycle
//   overflow                 : sticky, a key arrived while the buffer was full
//   typer_done               : typer idle (its finished flag)
//   start_writing_character  : one-cycle write request
//   row_num, col_num         : cell of the request
//   character_out            : glyph code of the request
//   cursor_row, cursor_col   : current cursor
// -----------------------------------------------------------------------------
module text_cursor_ctrl
    import text_cursor_ctrl_pkg::*;
#(
    parameter int         NUM_COLS   = 32,
    parameter int         NUM_ROWS   = 7,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_ascii,
    output logic       key_ready,
    output logic       overflow,
    input  logic       typer_done,
    output logic       start_writing_character,
    output logic [7:0] row_num,
    output logic [7:0] col_num,
    output logic [7:0] character_out,
    output logic [7:0] cursor_row,
    output logic [7:0] cursor_col
);

    localparam logic [7:0] LAST_COL = 8'(NUM_COLS - 1);
    localparam logic [7:0] LAST_ROW = 8'(NUM_ROWS - 1);

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [7:0]  code_r;
    code_class_e code_class_s;
    cursor_t     cursor_r;
    cursor_t     next_pos_s;
    cursor_t     prev_pos_s;
    cursor_t     newline_pos_s;
    logic        at_origin_s;

    logic        fifo_push_s;
    logic        fifo_pop_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic [7:0]  fifo_head_s;

    logic        overflow_r;
    logic        start_r;
    logic [7:0]  row_num_r;
    logic [7:0]  col_num_r;
    logic [7:0]  char_r;

    // Cell after p, wrapping at end of line and end of screen
    function automatic cursor_t advance_pos(input cursor_t p);
        cursor_t n;
        if (p.col == LAST_COL) begin
            n.col = 8'd0;
            n.row = (p.row == LAST_ROW) ? 8'd0 : (p.row + 8'd1);
        end else begin
            n.col = p.col + 8'd1;
            n.row = p.row;
        end
        return n;
    endfunction

    // Cell before p; from column 0 it moves to the end of the previous row.
    // Only used away from the origin.
    function automatic cursor_t retreat_pos(input cursor_t p);
        cursor_t n;
        if (p.col == 8'd0) begin
            n.col = LAST_COL;
            n.row = (p.row == 8'd0) ? LAST_ROW : (p.row - 8'd1);
        end else begin
            n.col = p.col - 8'd1;
            n.row = p.row;
        end
        return n;
    endfunction

    // Start of the next row, wrapping the bottom row to the top
    function automatic cursor_t newline_pos(input cursor_t p);
        cursor_t n;
        n.col = 8'd0;
        n.row = (p.row == LAST_ROW) ? 8'd0 : (p.row + 8'd1);
        return n;
    endfunction

    // Key buffer
    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_key_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push_s),
        .push_data (key_ascii),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign key_ready   = ~fifo_full_s;
    assign fifo_push_s = key_valid & ~fifo_full_s;
    // Only pull a new key once the typer is idle, so a pending request never
    // has to be held back behind a busy typer.
    assign fifo_pop_s  = (state_r == ST_IDLE) & ~fifo_empty_s & typer_done;

    assign code_class_s  = classify_code(code_r);
    assign at_origin_s   = (cursor_r.row == 8'd0) && (cursor_r.col == 8'd0);
    assign next_pos_s    = advance_pos(cursor_r);
    assign prev_pos_s    = retreat_pos(cursor_r);
    assign newline_pos_s = newline_pos(cursor_r);

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && typer_done) begin
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                case (code_class_s)
                    CLS_PRINT: state_nxt_s = ST_ISSUE;
                    CLS_BACKSPACE: begin
                        if (at_origin_s) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_ISSUE;
                        end
                    end
                    default: state_nxt_s = ST_IDLE;
                endcase
            end
            ST_ISSUE: state_nxt_s = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!typer_done) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (typer_done) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Holds the key code being processed, loaded on pop
    always_ff @(posedge clock) begin
        if (reset) begin
            code_r <= 8'h00;
        end else if (fifo_pop_s) begin
            code_r <= fifo_head_s;
        end
    end

    // Request outputs; start is high exactly while the FSM is in ISSUE, and
    // the cell/glyph stay frozen from ISSUE until the next DECODE.
    always_ff @(posedge clock) begin
        if (reset) begin
            start_r   <= 1'b0;
            row_num_r <= 8'd0;
            col_num_r <= 8'd0;
            char_r    <= 8'h00;
        end else begin
            start_r <= (state_nxt_s == ST_ISSUE);
            if (state_r == ST_DECODE) begin
                case (code_class_s)
                    CLS_PRINT: begin
                        row_num_r <= cursor_r.row;
                        col_num_r <= cursor_r.col;
                        char_r    <= code_r;
                    end
                    CLS_BACKSPACE: begin
                        if (!at_origin_s) begin
                            row_num_r <= prev_pos_s.row;
                            col_num_r <= prev_pos_s.col;
                            char_r    <= BLANK_CHAR;
                        end
                    end
                    default: begin
                        row_num_r <= row_num_r;
                    end
                endcase
            end
        end
    end

    // Cursor: newline/backspace move it in DECODE, printable keys advance it
    // in ISSUE alongside the request.
    always_ff @(posedge clock) begin
        if (reset) begin
            cursor_r <= '{row: 8'd0, col: 8'd0};
        end else begin
            case (state_r)
                ST_DECODE: begin
                    case (code_class_s)
                        CLS_NEWLINE: cursor_r <= newline_pos_s;
                        CLS_BACKSPACE: begin
                            if (!at_origin_s) begin
                                cursor_r <= prev_pos_s;
                            end
                        end
                        default: cursor_r <= cursor_r;
                    endcase
                end
                ST_ISSUE: begin
                    if (code_class_s == CLS_PRINT) begin
                        cursor_r <= next_pos_s;
                    end
                end
                default: cursor_r <= cursor_r;
            endcase
        end
    end

    // Sticky overflow: a key offered while the buffer is full is lost
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (key_valid && fifo_full_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign overflow                = overflow_r;
    assign start_writing_character = start_r;
    assign row_num                 = row_num_r;
    assign col_num                 = col_num_r;
    assign character_out           = char_r;
    assign cursor_row              = cursor_r.row;
    assign cursor_col              = cursor_r.col;

endmodule
